mux12_rr_sched: RTL and testbench
=================================

// Module: mux12_rr_sched
// PURPOSE
//  Round-robin scheduler owning the mux12 12:1 lattice-data mux (9 x 32b D2Q9 populations per beat).
//  Arbitrates 12 requesters (node PEs / stream buffers) and drives the mux select.
//  Forwards the granted requester's data downstream with a valid/ready handshake.
//  Bounds each grant to BURST_MAX beats for fairness.
// PARAMETERS
//  DATA_WIDTH  288  width of one beat (9 populations x 32b, signed)
//  N_REQ       12   requesters; fixed at 12, matches mux12 inputs
//  BURST_MAX   4    max beats per grant, >=1
// PORTS
//  clk        in   1                 single clock; all state on rising edge
//  reset_n    in   1                 asynchronous, active-low reset
//  req        in   N_REQ             req[i]: requester i has a beat on din_flat slice i
//  din_flat   in   N_REQ*DATA_WIDTH  slice i = [i*DATA_WIDTH +: DATA_WIDTH]
//  cfg_mask   in   N_REQ             1 = requester enabled; 0 = never newly granted
//  dout       out  DATA_WIDTH        mux12 output for current sel
//  dout_valid out  1                 beat valid downstream
//  dout_ready in   1                 downstream accepts beat
//  grant      out  N_REQ             one-hot holder; beat pops requester i when grant[i]&dout_ready
//  sel        out  4                 registered mux select, 0..11 only
//  busy       out  1                 high in GRANT state
// BEHAVIOUR
//  Reset (async assert, sync deassert): state=IDLE, sel=0, grant=0, busy=0, dout_valid=0,
//   beat_cnt=0, last_idx=11 (first search starts at requester 0).
//  Eligible = req & cfg_mask. Pick = first eligible index searching last_idx+1 .. last_idx (mod 12).
//  IDLE: eligible!=0 -> register sel=pick, grant=onehot(pick), beat_cnt=0, last_idx=pick, go GRANT.
//   Latency: req rises cycle t -> grant/dout_valid at t+1.
//  GRANT: dout_valid = req[sel] (combinational); beat = dout_valid & dout_ready.
//   beat -> beat_cnt++.
//   Release when (beat & beat_cnt==BURST_MAX-1) OR (!req[sel], i.e. withdrawal; no beat counted).
//   Release, eligible!=0: re-pick that cycle and register the new grant; no idle bubble.
//    Holder re-granted only if no other eligible requester.
//   Release, eligible==0: go IDLE; grant=0, sel holds last value.
//   dout_ready low: sel/grant/beat_cnt stable; dout held by stable sel.
//  cfg_mask clear on current holder: burst continues to normal release; not re-granted afterwards.
//  Simultaneous release and new req on another index: new index competes in that same pick.
//  sel never outside 0..11; grant always one-hot or zero; dout_valid=0 whenever grant==0.
//  Reset mid-burst: grant, dout_valid drop immediately (async); in-flight beat is lost.
//  beat_cnt width $clog2(BURST_MAX+1); BURST_MAX=1 releases on every beat.
// STRUCTURE
//  Package lbm_sched_pkg: N_REQ=12, SEL_W=4, D2Q9_WIDTH=288, typedef enum {IDLE,GRANT} sched_state_t.
//  Sub-modules:
//   - mux12 (existing) for the datapath, select driven by sel.
//   - rr_pick12: combinational rotate-priority encoder, (eligible, last_idx) -> pick, pick_valid.
//  FSM, counters and registers in this module.
// TESTING
//  1. req=12'h001, ready=1 -> cycle+1 grant=12'h001, sel=0, dout=din slice 0; 4 beats, then re-grant 0 (alone).
//  2. req=12'hFFF, ready=1, BURST_MAX=4 -> sel order 0,1,...,11,0; 4 beats each; no idle cycle between grants.
//  3. Holder 5, dout_ready low 10 cycles -> sel=5, beat_cnt frozen; ready high -> remaining beats complete.
//  4. Holder 3 drops req after 1 beat, req[7] high -> next cycle sel=7; req[3] relaunch waits its turn.
//  5. cfg_mask=12'hF7F, req=12'h880 -> only 11 granted; 7 never granted; dout_valid=0 when no eligible.
//  6. reset_n low mid-burst on sel=9 -> grant=0, dout_valid=0 same cycle; after release first pick is 0.

Source files
------------

// File: rtl/lbm_sched_pkg.sv
// Shared constants and types for the mux12 round-robin scheduler.
// Holds the requester count, select width, D2Q9 beat width and the FSM state type,
// plus a small one-hot helper used when registering a new grant.
package lbm_sched_pkg;

   localparam int N_REQ      = 12;
   localparam int SEL_W      = 4;
   localparam int D2Q9_WIDTH = 288;   // 9 populations x 32b

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } sched_state_t;

   // One-hot vector for a requester index; callers only pass 0..N_REQ-1.
   function automatic logic [N_REQ-1:0] onehot12(input logic [SEL_W-1:0] idx);
      logic [N_REQ-1:0] v;
      v = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/mux12_rr_sched_mux12.sv
// Purpose: 12:1 lattice-data mux, one D2Q9 beat per input slice.
// Ports:   din_flat_i (12 packed beats, slice i at [i*W +: W]), sel_i (0..11), dout_o.
// Purely combinational; out-of-range selects produce zero.
module mux12
   import lbm_sched_pkg::*;
#(
   parameter int DATA_WIDTH = D2Q9_WIDTH
) (
   input  logic [N_REQ*DATA_WIDTH-1:0] din_flat_i,
   input  logic [SEL_W-1:0]            sel_i,
   output logic [DATA_WIDTH-1:0]       dout_o
);

   always_comb begin
      dout_o = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (sel_i == SEL_W'(i)) begin
            dout_o = din_flat_i[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

endmodule

// File: rtl/mux12_rr_sched_pick.sv
// Purpose: rotating-priority encoder over 12 requesters.
// Ports:   elig_i (eligible vector), last_idx_i (previous winner, 0..11),
//          pick_o (first eligible after last_idx_i, wrapping), pick_valid_o (any eligible).
module rr_pick12
   import lbm_sched_pkg::*;
(
   input  logic [N_REQ-1:0] elig_i,
   input  logic [SEL_W-1:0] last_idx_i,
   output logic [SEL_W-1:0] pick_o,
   output logic             pick_valid_o
);

   logic [SEL_W:0]   sum;
   logic [SEL_W-1:0] idx;

   // Walk from the farthest offset (last_idx itself) towards the nearest
   // (last_idx+1) so the nearest eligible requester is the one left standing.
   // The previous winner therefore only wins when nobody else is eligible.
   always_comb begin
      pick_o       = '0;
      pick_valid_o = 1'b0;
      sum          = '0;
      idx          = '0;
      for (int k = N_REQ; k >= 1; k--) begin
         sum = {1'b0, last_idx_i} + (SEL_W+1)'(k);
         if (sum >= (SEL_W+1)'(N_REQ)) begin
            sum = sum - (SEL_W+1)'(N_REQ);
         end
         idx = sum[SEL_W-1:0];
         if (elig_i[idx]) begin
            pick_o       = idx;
            pick_valid_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mux12_rr_sched.sv
// Purpose: round-robin scheduler driving the mux12 lattice-data mux; grants one of 12
//          requesters for up to BURST_MAX beats and forwards its data downstream.
// Ports:   clk/reset_n; req, din_flat, cfg_mask in; dout/dout_valid out with dout_ready in;
//          grant (one-hot holder), sel (registered mux select), busy (holding a grant).
module mux12_rr_sched
   import lbm_sched_pkg::*;
#(
   parameter int DATA_WIDTH = D2Q9_WIDTH,
   parameter int BURST_MAX  = 4
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic [N_REQ-1:0]            req,
   input  logic [N_REQ*DATA_WIDTH-1:0] din_flat,
   input  logic [N_REQ-1:0]            cfg_mask,
   output logic [DATA_WIDTH-1:0]       dout,
   output logic                        dout_valid,
   input  logic                        dout_ready,
   output logic [N_REQ-1:0]            grant,
   output logic [SEL_W-1:0]            sel,
   output logic                        busy
);

   localparam int                 CNT_W    = $clog2(BURST_MAX + 1);
   localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(BURST_MAX - 1);
   localparam logic [SEL_W-1:0]   SEL_LAST = SEL_W'(N_REQ - 1);

   sched_state_t      state_q;
   logic [SEL_W-1:0]  sel_q;
   logic [N_REQ-1:0]  grant_q;
   logic [CNT_W-1:0]  beat_cnt_q;
   logic [CNT_W-1:0]  beat_cnt_d;
   logic [SEL_W-1:0]  last_idx_q;

   logic [N_REQ-1:0]  eligible;
   logic [SEL_W-1:0]  pick;
   logic              pick_valid;
   logic              holder_req;
   logic              beat;
   logic              burst_done;
   logic              rel;

   // A masked holder is still eligible to finish its burst: the mask only
   // gates new picks, and the holder's own req is what keeps the burst alive.
   assign eligible   = req & cfg_mask;
   assign holder_req = req[sel_q];
   assign dout_valid = (state_q == GRANT) & holder_req;
   assign beat       = dout_valid & dout_ready;
   assign burst_done = beat & (beat_cnt_q == CNT_LAST);
   // Withdrawal releases without counting a beat (dout_valid is low then).
   assign rel        = (state_q == GRANT) & (burst_done | ~holder_req);
   assign beat_cnt_d = beat_cnt_q + CNT_W'(1);

   assign grant = grant_q;
   assign sel   = sel_q;
   assign busy  = (state_q == GRANT);

   rr_pick12 u_pick (
      .elig_i       (eligible),
      .last_idx_i   (last_idx_q),
      .pick_o       (pick),
      .pick_valid_o (pick_valid)
   );

   mux12 #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_mux (
      .din_flat_i (din_flat),
      .sel_i      (sel_q),
      .dout_o     (dout)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         sel_q      <= '0;
         grant_q    <= '0;
         beat_cnt_q <= '0;
         last_idx_q <= SEL_LAST;   // first search starts at requester 0
      end else begin
         case (state_q)
            IDLE: begin
               if (pick_valid) begin
                  state_q    <= GRANT;
                  sel_q      <= pick;
                  grant_q    <= onehot12(pick);
                  beat_cnt_q <= '0;
                  last_idx_q <= pick;
               end
            end
            GRANT: begin
               if (rel) begin
                  // Re-pick in the release cycle so back-to-back grants have no bubble.
                  if (pick_valid) begin
                     sel_q      <= pick;
                     grant_q    <= onehot12(pick);
                     beat_cnt_q <= '0;
                     last_idx_q <= pick;
                  end else begin
                     state_q    <= IDLE;
                     grant_q    <= '0;
                     beat_cnt_q <= '0;
                  end
               end else if (beat) begin
                  beat_cnt_q <= beat_cnt_d;
               end
            end
            default: begin
               state_q <= IDLE;
               grant_q <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mux12_rr_sched.sv
// Bench for mux12_rr_sched: directed scenarios plus randomized traffic, all checked
// against an integer-level round-robin model of the scheduling rules.
module tb_mux12_rr_sched;

   localparam int W  = 288;
   localparam int N  = 12;
   localparam int BM = 4;

   logic           clk = 1'b0;
   logic           reset_n;
   logic [N-1:0]   req;
   logic [N*W-1:0] din_flat;
   logic [N-1:0]   cfg_mask;
   logic [W-1:0]   dout;
   logic           dout_valid;
   logic           dout_ready;
   logic [N-1:0]   grant;
   logic [3:0]     sel;
   logic           busy;

   int checks   = 0;
   int failures = 0;

   // Reference model state: holder index (-1 = none), beats taken, last winner, select.
   int m_holder;
   int m_cnt;
   int m_last;
   int m_sel;

   logic [N-1:0] exp_grant;
   logic [3:0]   exp_sel;
   logic         exp_valid;
   logic         exp_busy;
   logic [W-1:0] exp_dout;

   always #5 clk = ~clk;

   mux12_rr_sched #(.DATA_WIDTH(W), .BURST_MAX(BM)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .req        (req),
      .din_flat   (din_flat),
      .cfg_mask   (cfg_mask),
      .dout       (dout),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .grant      (grant),
      .sel        (sel),
      .busy       (busy)
   );

   // ---------------- reference model ----------------
   function automatic int rr_ref(input logic [N-1:0] e, input int last);
      for (int k = 1; k <= N; k++) begin
         if (e[(last + k) % N]) return (last + k) % N;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_holder = -1;
      m_cnt    = 0;
      m_last   = N - 1;
      m_sel    = 0;
   endtask

   task automatic model_take(input int p);
      m_holder = p;
      m_last   = p;
      m_sel    = p;
      m_cnt    = 0;
   endtask

   // Called at a rising edge with the inputs the DUT is sampling.
   task automatic model_advance();
      int   p;
      logic b;
      logic r;
      if (!reset_n) begin
         model_reset();
         return;
      end
      p = rr_ref(req & cfg_mask, m_last);
      if (m_holder < 0) begin
         if (p >= 0) model_take(p);
      end else begin
         b = req[m_holder] && dout_ready;
         r = !req[m_holder] || (b && (m_cnt + 1 == BM));
         if (r) begin
            if (p >= 0) model_take(p);
            else begin
               m_holder = -1;
               m_cnt    = 0;
            end
         end else if (b) begin
            m_cnt++;
         end
      end
   endtask

   task automatic model_eval();
      exp_grant = (m_holder >= 0) ? (12'd1 << m_holder) : 12'd0;
      exp_sel   = 4'(m_sel);
      exp_valid = (m_holder >= 0) && req[m_holder];
      exp_busy  = (m_holder >= 0);
      exp_dout  = din_flat[m_sel*W +: W];
   endtask

   // ---------------- stimulus plumbing ----------------
   task automatic rand_din();
      for (int i = 0; i < N*W/32; i++) din_flat[i*32 +: 32] = $urandom();
   endtask

   // Advance the model on the edge, drive new inputs just after it, and leave
   // the bench at the falling edge with expected outputs ready for comparison.
   task automatic drive_cycle(input logic [N-1:0] r, input logic [N-1:0] m, input logic rdy);
      @(posedge clk);
      model_advance();
      #1;
      req        = r;
      cfg_mask   = m;
      dout_ready = rdy;
      rand_din();
      @(negedge clk);
      model_eval();
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n    = 1'b0;
      req        = '0;
      cfg_mask   = '1;
      dout_ready = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      model_eval();
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      logic [W-1:0] s0;
      reset_n    = 1'b0;
      req        = '0;
      cfg_mask   = '1;
      dout_ready = 1'b0;
      rand_din();
      model_reset();
      #3;
      s0 = din_flat[W-1:0];
      checks++;
      if ({grant, sel, busy, dout_valid} !== {12'h000, 4'd0, 1'b0, 1'b0}) begin
         failures++;
         $display("FAIL reset_state got grant=%h sel=%0d busy=%b vld=%b exp 000/0/0/0", grant, sel, busy, dout_valid);
      end
      checks++;
      if (dout !== s0) begin
         failures++;
         $display("FAIL reset_dout got %h exp %h", dout, s0);
      end
      do_reset();
      repeat (2) begin
         drive_cycle('0, '1, 1'b1);
         checks++;
         if ({grant, sel, busy, dout_valid} !== {exp_grant, exp_sel, exp_busy, exp_valid}) begin
            failures++;
            $display("FAIL reset_idle got grant=%h sel=%0d busy=%b vld=%b exp %h/%0d/%b/%b",
                     grant, sel, busy, dout_valid, exp_grant, exp_sel, exp_busy, exp_valid);
         end
      end
   endtask

   task automatic test_single();
      do_reset();
      drive_cycle(12'h001, '1, 1'b1);
      checks++;
      if (grant !== 12'h000) begin
         failures++;
         $display("FAIL single_latency got grant=%h exp 000", grant);
      end
      for (int c = 0; c < 10; c++) begin
         drive_cycle(12'h001, '1, 1'b1);
         checks++;
         if ({grant, sel, dout_valid} !== {12'h001, 4'd0, 1'b1}) begin
            failures++;
            $display("FAIL single_hold c=%0d got grant=%h sel=%0d vld=%b exp 001/0/1", c, grant, sel, dout_valid);
         end
         checks++;
         if (dout !== exp_dout) begin
            failures++;
            $display("FAIL single_dout c=%0d got %h exp %h", c, dout, exp_dout);
         end
      end
   endtask

   task automatic test_all_req();
      do_reset();
      drive_cycle(12'hFFF, '1, 1'b1);
      for (int j = 0; j < 4*N + 4; j++) begin
         drive_cycle(12'hFFF, '1, 1'b1);
         checks++;
         if ({sel, dout_valid} !== {4'((j / BM) % N), 1'b1}) begin
            failures++;
            $display("FAIL all_req_order j=%0d got sel=%0d vld=%b exp sel=%0d vld=1", j, sel, dout_valid, (j / BM) % N);
         end
         checks++;
         if ({grant, dout} !== {exp_grant, exp_dout}) begin
            failures++;
            $display("FAIL all_req_model j=%0d got grant=%h exp grant=%h", j, grant, exp_grant);
         end
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      drive_cycle(12'h060, '1, 1'b1);
      drive_cycle(12'h060, '1, 1'b1);   // grant 5, first beat taken
      for (int c = 0; c < 10; c++) begin
         drive_cycle(12'h060, '1, 1'b0);
         checks++;
         if ({grant, sel, dout_valid} !== {12'h020, 4'd5, 1'b1}) begin
            failures++;
            $display("FAIL bp_stall c=%0d got grant=%h sel=%0d vld=%b exp 020/5/1", c, grant, sel, dout_valid);
         end
      end
      for (int c = 0; c < 3; c++) begin
         drive_cycle(12'h060, '1, 1'b1);
         checks++;
         if ({sel, dout} !== {4'd5, exp_dout} || sel !== exp_sel) begin
            failures++;
            $display("FAIL bp_resume c=%0d got sel=%0d exp 5", c, sel);
         end
      end
      drive_cycle(12'h060, '1, 1'b1);
      checks++;
      if ({grant, sel} !== {12'h040, 4'd6}) begin
         failures++;
         $display("FAIL bp_next got grant=%h sel=%0d exp 040/6", grant, sel);
      end
   endtask

   task automatic test_withdraw();
      logic [N-1:0] rq [8];
      int           es [8];
      logic         ev [8];
      rq = '{12'h088, 12'h088, 12'h080, 12'h088, 12'h088, 12'h088, 12'h088, 12'h088};
      es = '{0, 3, 3, 7, 7, 7, 7, 3};
      ev = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      do_reset();
      for (int s = 0; s < 8; s++) begin
         drive_cycle(rq[s], '1, 1'b1);
         checks++;
         if ({sel, dout_valid} !== {4'(es[s]), ev[s]}) begin
            failures++;
            $display("FAIL withdraw s=%0d got sel=%0d vld=%b exp sel=%0d vld=%b", s, sel, dout_valid, es[s], ev[s]);
         end
         checks++;
         if ({grant, busy} !== {exp_grant, exp_busy}) begin
            failures++;
            $display("FAIL withdraw_model s=%0d got grant=%h busy=%b exp %h/%b", s, grant, busy, exp_grant, exp_busy);
         end
      end
   endtask

   task automatic test_mask();
      do_reset();
      for (int c = 0; c < 24; c++) begin
         drive_cycle(12'h880, 12'hF7F, 1'($urandom_range(0, 1)));
         checks++;
         if (grant[7] !== 1'b0 || {grant, sel, dout_valid} !== {exp_grant, exp_sel, exp_valid}) begin
            failures++;
            $display("FAIL mask c=%0d got grant=%h sel=%0d vld=%b exp %h/%0d/%b",
                     c, grant, sel, dout_valid, exp_grant, exp_sel, exp_valid);
         end
      end
      for (int c = 0; c < 4; c++) begin
         drive_cycle(12'h080, 12'hF7F, 1'b1);
         checks++;
         if (dout_valid !== 1'b0 || (c > 0 && grant !== 12'h000)) begin
            failures++;
            $display("FAIL mask_idle c=%0d got grant=%h vld=%b exp vld=0", c, grant, dout_valid);
         end
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      drive_cycle(12'h200, '1, 1'b1);
      drive_cycle(12'h200, '1, 1'b1);
      drive_cycle(12'h200, '1, 1'b1);
      checks++;
      if ({grant, sel} !== {12'h200, 4'd9}) begin
         failures++;
         $display("FAIL rmid_pre got grant=%h sel=%0d exp 200/9", grant, sel);
      end
      #2;
      reset_n = 1'b0;
      #1;
      checks++;
      if ({grant, dout_valid, busy} !== {12'h000, 1'b0, 1'b0}) begin
         failures++;
         $display("FAIL rmid_async got grant=%h vld=%b busy=%b exp 000/0/0", grant, dout_valid, busy);
      end
      model_reset();
      req = 12'h201;
      @(negedge clk);
      reset_n = 1'b1;
      drive_cycle(12'h201, '1, 1'b1);
      checks++;
      if ({grant, sel, dout_valid} !== {12'h001, 4'd0, 1'b1} || grant !== exp_grant) begin
         failures++;
         $display("FAIL rmid_first got grant=%h sel=%0d vld=%b exp 001/0/1", grant, sel, dout_valid);
      end
   endtask

   task automatic test_random();
      logic [N-1:0] r;
      logic [N-1:0] m;
      do_reset();
      r = '0;
      m = '1;
      for (int c = 0; c < 1500; c++) begin
         for (int b = 0; b < N; b++) begin
            if ($urandom_range(0, 4) == 0) r[b] = ~r[b];
         end
         if ($urandom_range(0, 19) == 0) m = ($urandom_range(0, 1) == 0) ? 12'hFFF : 12'($urandom());
         drive_cycle(r, m, 1'($urandom_range(0, 3) != 0));
         checks++;
         if ({grant, sel, dout_valid, busy} !== {exp_grant, exp_sel, exp_valid, exp_busy}) begin
            failures++;
            $display("FAIL random c=%0d got grant=%h sel=%0d vld=%b busy=%b exp %h/%0d/%b/%b",
                     c, grant, sel, dout_valid, busy, exp_grant, exp_sel, exp_valid, exp_busy);
         end
         checks++;
         if (dout !== exp_dout) begin
            failures++;
            $display("FAIL random_dout c=%0d got %h exp %h", c, dout, exp_dout);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_all_req();
      test_backpressure();
      test_withdraw();
      test_mask();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
